spi_master_fifo: RTL



---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync_fifo.sv | 44 ++++
 rtl/spi_master_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and slave-select helpers for the SPI master.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  localparam int MAX_SLAVES = 64;
  function automatic int ss_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [MAX_SLAVES-1:0] ss_inactive(input bit active_low);
    return active_low ? '1 : '0;
  endfunction
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous FIFO with valid/ready on both sides; a pop frees room for a same-cycle push.
module spi_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_valid = !o_empty;
  assign w_pop = o_valid && i_ready;
  assign o_ready = !o_full || w_pop;
  assign w_push = i_valid && o_ready;
  assign o_data = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: SPI master with TX/RX FIFOs, run-time mode/divider/bit order and burst SS hold.
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int NUM_SLAVES       = 4,
  parameter int FIFO_DEPTH       = 16,
  parameter int DIV_WIDTH        = 16,
  parameter bit SLAVE_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_cpol,
  input  logic                        cfg_cpha,
  input  logic                        cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [ss_w(NUM_SLAVES)-1:0] cfg_ss_sel,
  input  logic                        cfg_burst,
  input  logic                        enable,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        rx_ovf,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso,
  output logic [NUM_SLAVES-1:0]       ss
);
  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [NUM_SLAVES-1:0] SS_OFF = NUM_SLAVES'(ss_inactive(SLAVE_ACTIVE_LOW));
  state_t r_state, w_next;
  logic [DIV_WIDTH-1:0] r_cnt, r_div;
  logic [EW-1:0] r_edge;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, w_tx_data, w_rest;
  logic [NUM_SLAVES-1:0] r_ss;
  logic r_cpha, r_lsb, r_sclk, r_mosi, r_done;
  logic w_tx_avail, w_tx_pop, w_tx_full, w_tx_empty, w_rx_ready, w_rx_full, w_rx_empty, w_unused;
  logic w_tick, w_last, w_lead, w_drive, w_sample, w_start, w_burst, w_first;
  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .i_data(tx_data), .i_valid(tx_valid), .o_ready(tx_ready),
    .o_data(w_tx_data), .o_valid(w_tx_avail), .i_ready(w_tx_pop), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );
  spi_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .i_data(r_rx), .i_valid(r_done), .o_ready(w_rx_ready),
    .o_data(rx_data), .o_valid(rx_valid), .i_ready(rx_ready), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );
  assign w_unused = &{1'b0, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
  assign w_tick = r_cnt == r_div;
  assign w_last = r_edge == EW'(2 * DATA_WIDTH - 1);
  assign w_lead = !r_edge[0];
  assign w_drive = r_cpha ? w_lead : (!w_lead && !w_last);
  assign w_sample = r_cpha ? !w_lead : w_lead;
  assign w_start = r_state == IDLE && enable && w_tx_avail;
  assign w_burst = r_state == SHIFT && w_tick && w_last && cfg_burst && enable && w_tx_avail;
  assign w_tx_pop = w_start || w_burst;
  assign w_first = cfg_lsb_first ? w_tx_data[0] : w_tx_data[DATA_WIDTH-1];
  assign w_rest = cfg_lsb_first ? w_tx_data >> 1 : w_tx_data << 1;
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign rx_ovf = r_done && !w_rx_ready;
  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign ss = r_ss;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? SETUP : IDLE;
      SETUP:   w_next = w_tick ? SHIFT : SETUP;
      SHIFT:   w_next = !(w_tick && w_last) ? SHIFT : w_burst ? SETUP : HOLD;
      HOLD:    w_next = w_tick ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_div <= '0;
      r_edge <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_ss <= SS_OFF;
      r_cpha <= 1'b0;
      r_lsb <= 1'b0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == SHIFT && w_tick && w_last;
      r_cnt <= (r_state == IDLE || w_tick) ? '0 : r_cnt + DIV_WIDTH'(1);
      if (r_state == IDLE) r_sclk <= cfg_cpol;
      if (r_state == HOLD && w_tick) r_ss <= SS_OFF;
      if (r_state == SHIFT && w_tick) begin
        r_sclk <= !r_sclk;
        r_edge <= r_edge + EW'(1);
        if (w_drive) begin
          r_mosi <= r_lsb ? r_tx[0] : r_tx[DATA_WIDTH-1];
          r_tx <= r_lsb ? r_tx >> 1 : r_tx << 1;
        end
        if (w_sample) r_rx <= r_lsb ? {miso, r_rx[DATA_WIDTH-1:1]} : {r_rx[DATA_WIDTH-2:0], miso};
      end
      // A burst re-latch overrides the final edge's bookkeeping; ss_sel stays as latched from IDLE.
      if (w_tx_pop) begin
        r_div <= cfg_div;
        r_cpha <= cfg_cpha;
        r_lsb <= cfg_lsb_first;
        r_sclk <= cfg_cpol;
        r_edge <= '0;
        r_tx <= cfg_cpha ? w_tx_data : w_rest;
        if (!cfg_cpha) r_mosi <= w_first;
      end
      if (w_start) r_ss <= SS_OFF ^ (NUM_SLAVES'(1) << cfg_ss_sel);
    end
  end
endmodule
